// File: rtl/stepper_sequencer.sv
// Stepper motor move sequencer: accepts move commands and steps a 3-bit phase through the coil patterns, tracking absolute position.
// Latency: the first step lands `period` cycles after the acceptance edge; done pulses the cycle after the last step, abort or zero-length move.
// Backpressure: cmd_ready is high only in IDLE with enable=1 and a legal step_mode. Optional STEPPER_IDLE_OFF_EN de-energizes coils after IDLE_CYCLES idle cycles.
module stepper_sequencer #(
   parameter int DIV_W       = 16,
   parameter int CNT_W       = 16,
   parameter int POS_W       = 24,
   parameter int IDLE_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [1:0]       step_mode,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic [DIV_W-1:0] period,
   input  logic             abort,
   output logic [3:0]       coils,
   output logic             busy,
   output logic             done,
   output logic [POS_W-1:0] position
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [2:0]       phase;
   logic [POS_W-1:0] pos_q;
   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] per_q;
   logic [CNT_W-1:0] remaining;
   logic             dir_q;
   logic [1:0]       mode_q;
   logic             busy_q;
   logic             done_q;
   logic             accept;
   logic             tick;
   logic             idle_off;

   // Phase advance for one step: full step settles on odd phases, wave drive on even ones.
   function automatic logic [2:0] next_phase(input logic [2:0] ph, input logic [1:0] mode, input logic dir);
      logic [2:0] inc;
      case (mode)
         2'b00:   inc = ph[0] ? 3'd2 : 3'd1;
         2'b10:   inc = ph[0] ? 3'd1 : 3'd2;
         default: inc = 3'd1;
      endcase
      return dir ? (ph + inc) : (ph - inc);
   endfunction

   // Phase to coil drive pattern.
   function automatic logic [3:0] phase_pattern(input logic [2:0] ph);
      logic [3:0] pat;
      case (ph)
         3'd0:    pat = 4'b1000;
         3'd1:    pat = 4'b1100;
         3'd2:    pat = 4'b0100;
         3'd3:    pat = 4'b0110;
         3'd4:    pat = 4'b0010;
         3'd5:    pat = 4'b0011;
         3'd6:    pat = 4'b0001;
         default: pat = 4'b1001;
      endcase
      return pat;
   endfunction

   assign cmd_ready = !rst && enable && (state == IDLE) && (step_mode != 2'b11);
   assign accept    = cmd_valid && cmd_ready;
   // Divider restarts at 1 on acceptance, so the tick falls exactly per_q edges later.
   assign tick      = (div_cnt == per_q);

   // Move FSM with divider, step counter, phase and position.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         phase     <= 3'd0;
         pos_q     <= '0;
         div_cnt   <= '0;
         per_q     <= '0;
         remaining <= '0;
         dir_q     <= 1'b0;
         mode_q    <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  dir_q     <= cmd_dir;
                  mode_q    <= step_mode;
                  per_q     <= (period == '0) ? DIV_W'(1) : period;
                  remaining <= cmd_steps;
                  div_cnt   <= DIV_W'(1);
                  if (cmd_steps == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     state  <= RUN;
                     busy_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (!enable) begin
                  // Disable drops the move silently; phase and position are kept.
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end else if (abort) begin
                  // Abort beats a coincident tick: no step is taken.
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end else if (tick) begin
                  phase     <= next_phase(phase, mode_q, dir_q);
                  pos_q     <= dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                  remaining <= remaining - CNT_W'(1);
                  div_cnt   <= DIV_W'(1);
                  if (remaining == CNT_W'(1)) begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                  end
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef STEPPER_IDLE_OFF_EN
   localparam int TMR_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(IDLE_CYCLES);

   logic [TMR_W-1:0] idle_tmr;

   // Count consecutive IDLE cycles, saturating; acceptance or a move restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_tmr <= '0;
      end else if (accept || (state == RUN)) begin
         idle_tmr <= '0;
      end else if (idle_tmr != TMR_MAX) begin
         idle_tmr <= idle_tmr + TMR_W'(1);
      end
   end

   assign idle_off = (state == IDLE) && (idle_tmr == TMR_MAX);
`else
   logic unused_idle_cycles;
   assign unused_idle_cycles = ^IDLE_CYCLES;
   assign idle_off = 1'b0;
`endif

   assign coils    = (enable && !rst && !idle_off) ? phase_pattern(phase) : 4'b0000;
   assign busy     = busy_q;
   assign done     = done_q;
   assign position = pos_q;

endmodule

// File: doc/stepper_sequencer.md
STEPPER_SEQUENCER -- requirements
Module: stepper_sequencer

Interface
REQ-001 Parameter DIV_W, default 16, width of the step-period divider.
REQ-002 Parameter CNT_W, default 16, width of the step-count field of a move command.
REQ-003 Parameter POS_W, default 24, width of the absolute position counter.
REQ-004 Parameter IDLE_CYCLES, default 1000000, idle timeout in clocks; used only under REQ-029.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  driver enable; low de-energizes the coils and aborts any move.
REQ-008 step_mode  input  2  00 full step, 01 half step, 10 wave drive, 11 reserved.
REQ-009 cmd_valid  input  1  move command offered.
REQ-010 cmd_ready  output  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-011 cmd_dir  input  1  1 forward (phase and position increment), 0 reverse.
REQ-012 cmd_steps  input  CNT_W  number of steps in the move.
REQ-013 period  input  DIV_W  clocks per step.
REQ-014 abort  input  1  terminate the active move.
REQ-015 coils  output  4  coil drive pattern.
REQ-016 busy  output  1  high while in RUN.
REQ-017 done  output  1  one-cycle pulse at move end.
REQ-018 position  output  POS_W  absolute step position, two's complement.

Function
REQ-019 FSM states: IDLE and RUN; cmd_ready SHALL be high only in IDLE, with enable=1 and step_mode!=11.
REQ-020 On acceptance: latch cmd_dir, cmd_steps, step_mode, and period (0 treated as 1); if cmd_steps=0, pulse done next cycle and stay in IDLE; otherwise enter RUN next cycle.
REQ-021 In RUN, a divider counts latched period clocks; the first step tick SHALL occur exactly period cycles after the acceptance edge, and subsequent ticks every period cycles.
REQ-022 On each tick: advance the 3-bit phase by the mode increment in the latched direction (mod 8), change position by ±1 (wrap mod 2^POS_W), and decrement the remaining count.
REQ-023 Mode increments: half = 1; full = 1 if the current phase is even, else 2 (settles on odd phases); wave = 1 if the current phase is odd, else 2 (settles on even phases).
REQ-024 When the tick that brings remaining to 0 occurs, pulse done in the next cycle and return to IDLE in the next cycle; a new command SHALL be acceptable in that same cycle.
REQ-025 Phase-to-coils mapping: 0=1000, 1=1100, 2=0100, 3=0110, 4=0010, 5=0011, 6=0001, 7=1001; coils SHALL be 0000 when enable=0.
REQ-026 abort in RUN: return to IDLE next cycle and pulse done; if abort and a tick coincide, abort wins and no step is taken.
REQ-027 enable=0 in RUN: return to IDLE next cycle with no done pulse; phase and position SHALL be retained.
REQ-028 The remaining count, phase, and position SHALL be readable only through coils and position; changes to step_mode or period mid-move SHALL have no effect.

Configuration
REQ-029 When STEPPER_IDLE_OFF_EN is defined: after IDLE_CYCLES consecutive cycles in IDLE, coils SHALL be 0000 until the next command acceptance; the phase pattern SHALL reappear in the cycle after acceptance, and the phase SHALL be unchanged. When the macro is undefined, coils SHALL hold the current phase pattern indefinitely while enable=1.

Reset
REQ-030 While rst=1: state IDLE, phase 0, position 0, divider 0, remaining 0, busy 0, done 0, cmd_ready 0, coils 0000, idle timer 0.
REQ-031 First cycle after rst is released with enable=1: coils=1000, cmd_ready=1 (if step_mode!=11); rst mid-move SHALL abort without a done pulse.

Verification
REQ-032 Half mode, forward, steps=4, period=3, from reset: ticks at 3, 6, 9, 12 cycles after acceptance -> coils 1100, 0100, 0110, 0010; position=4; single done pulse.
REQ-033 Full mode, reverse, steps=3, starting at phase 0 -> phases 7, 5, 3 (coils 1001, 0011, 0110); position=-3 (all ones minus 2).
REQ-034 Wave mode, forward, starting at phase 3, steps=2 -> phases 4, 6; then cmd_steps=0 -> done pulse next cycle, busy never high.
REQ-035 abort asserted on the same cycle as the 2nd tick of a 5-step move -> position changed by 1, done pulses, cmd_ready high the next cycle.
REQ-036 POS_W=4, position 7, forward 1 step -> position 8 (-8); with STEPPER_IDLE_OFF_EN and IDLE_CYCLES=10 -> coils 0000 after 10 idle cycles and restored the cycle after the next acceptance.
